// File: rtl/csa_carry_resolve.sv
// csa_carry_resolve: segmented, pipelined carry-propagate resolution of a CSA sum/carry/co triple
module csa_carry_resolve #(
  parameter int width     = 14,
  parameter int seg_width = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] sum,
  input  logic [width-1:0] carry,
  input  logic             co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width+1:0] res
);
  localparam int nstg = (width + seg_width - 1) / seg_width;
  logic             v_q   [nstg];
  logic             co_q  [nstg];
  logic             cy_q  [nstg];
  logic [width-1:0] s_q   [nstg];
  logic [width-1:0] c_q   [nstg];
  logic             v_in  [nstg];
  logic             co_in [nstg];
  logic             cy_d  [nstg];
  logic [width-1:0] c_in  [nstg];
  logic [width-1:0] s_d   [nstg];
  logic [width+1:0] res_d;
  logic [width+1:0] res_q;
  logic             adv;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[nstg-1];
  assign res       = res_q;
  for (genvar k = 0; k < nstg; k++) begin : g_stg
    localparam int lo = k * seg_width;
    localparam int w  = (width - lo < seg_width) ? width - lo : seg_width;
    logic [width-1:0] s_in;
    logic             cin;
    logic [w:0]       add;
    if (k == 0) begin : g_first
      assign s_in     = sum;
      assign c_in[k]  = carry;
      assign cin      = 1'b0;
      assign co_in[k] = co;
      assign v_in[k]  = in_valid;
    end else begin : g_next
      assign s_in     = s_q[k-1];
      assign c_in[k]  = c_q[k-1];
      assign cin      = cy_q[k-1];
      assign co_in[k] = co_q[k-1];
      assign v_in[k]  = v_q[k-1];
    end
    // resolved bits overwrite this segment of the forwarded sum word in place
    assign add     = {1'b0, s_in[lo+:w]} + {1'b0, c_in[k][lo+:w]} + {{w{1'b0}}, cin};
    assign s_d[k]  = (s_in & ~((width)'({w{1'b1}}) << lo)) | ((width)'(add[w-1:0]) << lo);
    assign cy_d[k] = add[w];
  end
  assign res_d = {2'(co_in[nstg-1]) + 2'(cy_d[nstg-1]), s_d[nstg-1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < nstg; i++) begin
        v_q[i]  <= 1'b0;
        co_q[i] <= 1'b0;
        cy_q[i] <= 1'b0;
        s_q[i]  <= '0;
        c_q[i]  <= '0;
      end
      res_q <= '0;
    end else if (adv) begin
      v_q   <= v_in;
      co_q  <= co_in;
      cy_q  <= cy_d;
      s_q   <= s_d;
      c_q   <= c_in;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_csa_carry_resolve.sv
// tb_csa_carry_resolve: scoreboard-based bench for the default 14-bit, two-stage configuration
module tb_csa_carry_resolve;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] sum = '0;
  logic [13:0] carry = '0;
  logic        co = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] res;
  logic [15:0] sb[$];
  logic        acc_in, acc_out;
  logic [15:0] e;
  int checks = 0;
  int failures = 0;

  csa_carry_resolve #(.width(14), .seg_width(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .co(co),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic [13:0] s, input logic [13:0] c,
                       input logic o, input logic rdy);
    @(negedge clk);
    rst = r; in_valid = v; sum = s; carry = c; co = o; out_ready = rdy;
    #1;
    acc_in  = !r && v && in_ready;
    acc_out = !r && out_valid && rdy;
    if (acc_in) sb.push_back({2'b00, s} + {2'b00, c} + {1'b0, o, 14'd0});
  endtask

  task automatic test_reset();
    drive(1, 1, 14'd3, 14'd3, 0, 1);
    drive(1, 1, 14'd3, 14'd3, 0, 1);
    drive(0, 0, 14'd0, 14'd0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (res !== 16'd0) begin failures++; $display("FAIL reset_res got=%h exp=0000", res); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    drive(0, 0, 14'd0, 14'd0, 0, 1);
    drive(0, 0, 14'd0, 14'd0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_beat_leak got=%b exp=0", out_valid); end
    sb.delete();
  endtask

  task automatic test_value(input string name, input logic [13:0] s, input logic [13:0] c,
                            input logic o, input logic [15:0] exp);
    drive(0, 1, s, c, o, 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 14'd0, 14'd0, 0, 1);
      checks++;
      if (out_valid !== (i == 2)) begin failures++; $display("FAIL %s_latency cyc=%0d got=%b exp=%b", name, i, out_valid, i == 2); end
      if (i == 2) begin
        checks++;
        if (res !== exp) begin failures++; $display("FAIL %s_res got=%h exp=%h", name, res, exp); end
      end
      if (acc_out && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (res !== e) begin failures++; $display("FAIL %s_model got=%h exp=%h", name, res, e); end
      end
    end
  endtask

  task automatic test_random();
    int sent = 0, cyc = 0;
    logic v, rdy;
    while ((sent < 40 || sb.size() > 0) && cyc < 600) begin
      v   = (sent < 40) && ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 3) != 0;
      drive(0, v, 14'($urandom), 14'($urandom), 1'($urandom), rdy);
      if (acc_in) sent++;
      if (out_valid && !rdy) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL random_in_ready got=%b exp=0", in_ready); end
      end
      if (acc_out) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL random_spurious got=%h exp=none", res); end
        else begin
          e = sb.pop_front();
          if (res !== e) begin failures++; $display("FAIL random_res got=%h exp=%h", res, e); end
        end
      end
      cyc++;
    end
    checks++;
    if (sent < 40 || sb.size() != 0) begin failures++; $display("FAIL random_timeout sent=%0d pending=%0d exp=40/0", sent, sb.size()); end
  endtask

  task automatic test_backpressure();
    int idx = 0, n = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, idx < 4, 14'(idx + 1), 14'd0, 0, !(c >= 2 && c < 5));
      if (acc_in) idx++;
      if (c >= 2 && c < 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== 16'd1) begin
          failures++; $display("FAIL bp_stall cyc=%0d in_ready=%b out_valid=%b res=%h exp=0/1/0001", c, in_ready, out_valid, res);
        end
      end
      if (acc_out) begin
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
        if (res !== e || res !== 16'(n + 1)) begin failures++; $display("FAIL bp_order got=%h exp=%h", res, 16'(n + 1)); end
        n++;
      end
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", n); end
  endtask

  task automatic test_bubbles();
    for (int c = 0; c < 6; c++) begin
      drive(0, c == 0 || c == 2, 14'(c + 9), 14'd1, 0, 1);
      checks++;
      if (out_valid !== (c == 2 || c == 4)) begin failures++; $display("FAIL bubble_valid cyc=%0d got=%b exp=%b", c, out_valid, c == 2 || c == 4); end
      if (acc_out) begin
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
        if (res !== e) begin failures++; $display("FAIL bubble_res got=%h exp=%h", res, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 14'd5, 14'd0, 0, 1);
    drive(0, 1, 14'd6, 14'd0, 0, 1);
    drive(1, 1, 14'd7, 14'd0, 0, 0);
    sb.delete();
    drive(0, 1, 14'h2AAA, 14'h1555, 1, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (res !== 16'd0) begin failures++; $display("FAIL rstmid_res got=%h exp=0000", res); end
    drive(0, 0, 14'd0, 14'd0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b exp=0", out_valid); end
    drive(0, 0, 14'd0, 14'd0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_new_valid got=%b exp=1", out_valid); end
    checks++; if (res !== 16'h7FFF) begin failures++; $display("FAIL rstmid_new_res got=%h exp=7fff", res); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_value("single", 14'h0001, 14'h0000, 0, 16'h0001);
    test_value("xseg", 14'h007F, 14'h0001, 0, 16'h0080);
    test_value("max", 14'h3FFF, 14'h3FFF, 1, 16'hBFFE);
    test_random();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
